// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, multi-cycle bubble
// insertion and branch-taken squash of the ID-stage instruction.
module id_ex_hazard_stage #(
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ID_Instruction,
    input  logic [4:0]  ID_RegisterDestination,
    input  logic        ID_RegisterWrite,
    input  logic        ID_MemRead,
    input  logic        BranchTaken,
    output logic [31:0] EX_Instruction,
    output logic [31:0] EX_RegisterDestination,
    output logic        EX_RegisterWrite,
    output logic        EX_MemRead,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic [15:0] StallCount
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

    // Jumps and lui carry no rs operand; everything else reads rs.
    function automatic logic uses_rs(input logic [5:0] op);
        logic used;
        case (op)
            6'b000010: used = 1'b0;
            6'b000011: used = 1'b0;
            6'b001111: used = 1'b0;
            default:   used = 1'b1;
        endcase
        return used;
    endfunction

    // R-type, beq/bne and stores read rt as a source; other formats write it.
    function automatic logic uses_rt(input logic [5:0] op);
        logic used;
        case (op)
            6'b000000: used = 1'b1;
            6'b000100: used = 1'b1;
            6'b000101: used = 1'b1;
            6'b101011: used = 1'b1;
            6'b101000: used = 1'b1;
            6'b101001: used = 1'b1;
            default:   used = 1'b0;
        endcase
        return used;
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] ex_ins_q, ex_ins_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_rw_q, ex_rw_d;
    logic        ex_mr_q, ex_mr_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic        hazard_s;
    logic        pc_write_s;
    logic        ifid_write_s;
    logic        ifid_flush_s;
    logic        insert_bubble_s;
    logic        count_bubble_s;

    // Load-use hazard: EX holds a load to a nonzero register that ID reads.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_mr_q && ex_rw_q && (ex_rd_q != 5'd0)) begin
            hazard_s = (uses_rs(ID_Instruction[31:26]) && (ID_Instruction[25:21] == ex_rd_q)) ||
                       (uses_rt(ID_Instruction[31:26]) && (ID_Instruction[20:16] == ex_rd_q));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Next-state, pipeline-register next values and pipeline control enables.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ex_ins_d        = ex_ins_q;
        ex_rd_d         = ex_rd_q;
        ex_rw_d         = ex_rw_q;
        ex_mr_d         = ex_mr_q;
        stall_count_d   = stall_count_q;
        pc_write_s      = 1'b0;
        ifid_write_s    = 1'b0;
        ifid_flush_s    = 1'b0;
        insert_bubble_s = 1'b0;
        count_bubble_s  = 1'b0;

        if (BranchTaken) begin
            pc_write_s      = 1'b1;
            ifid_write_s    = 1'b1;
            ifid_flush_s    = 1'b1;
            insert_bubble_s = 1'b1;
            state_d         = ST_RUN;
            cnt_d           = 3'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard_s) begin
                        insert_bubble_s = 1'b1;
                        count_bubble_s  = 1'b1;
                        if (MULTI_STALL) begin
                            cnt_d   = STALL_RELOAD;
                            state_d = ST_STALL;
                        end else begin
                            cnt_d   = cnt_q;
                            state_d = ST_RUN;
                        end
                    end else begin
                        pc_write_s   = 1'b1;
                        ifid_write_s = 1'b1;
                        ex_ins_d     = ID_Instruction;
                        ex_rd_d      = ID_RegisterDestination;
                        ex_rw_d      = ID_RegisterWrite;
                        ex_mr_d      = ID_MemRead;
                    end
                end
                ST_STALL: begin
                    insert_bubble_s = 1'b1;
                    count_bubble_s  = 1'b1;
                    cnt_d           = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
                default: begin
                    insert_bubble_s = 1'b1;
                    state_d         = ST_RUN;
                    cnt_d           = 3'd0;
                end
            endcase
        end

        if (insert_bubble_s) begin
            ex_ins_d = 32'd0;
            ex_rd_d  = 5'd0;
            ex_rw_d  = 1'b0;
            ex_mr_d  = 1'b0;
        end else begin
            ex_ins_d = ex_ins_d;
        end

        if (count_bubble_s && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, EX pipeline registers and bubble counter.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 3'd0;
            ex_ins_q      <= 32'd0;
            ex_rd_q       <= 5'd0;
            ex_rw_q       <= 1'b0;
            ex_mr_q       <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ex_ins_q      <= ex_ins_d;
            ex_rd_q       <= ex_rd_d;
            ex_rw_q       <= ex_rw_d;
            ex_mr_q       <= ex_mr_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign EX_Instruction         = ex_ins_q;
    assign EX_RegisterDestination = {27'd0, ex_rd_q};
    assign EX_RegisterWrite       = ex_rw_q;
    assign EX_MemRead             = ex_mr_q;
    assign StallCount             = stall_count_q;
    assign PCWrite                = Reset & pc_write_s;
    assign IFIDWrite              = Reset & ifid_write_s;
    assign IFIDFlush              = Reset & ifid_flush_s;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: three instances (1, 3 and 7 bubbles per
// load-use) share stimulus; directed vectors, hand sequences, random + model.
module tb_id_ex_hazard_stage;

    localparam logic [31:0] LW8  = 32'h8C08_0000;
    localparam logic [31:0] LW0  = 32'h8C00_0000;
    localparam logic [31:0] LW88 = 32'h8D08_0000;
    localparam logic [31:0] ADD  = 32'h010A_4820;
    localparam logic [31:0] SW   = 32'hAD28_0004;
    localparam logic [31:0] JMP  = 32'h0900_0000;
    localparam logic [31:0] ADD0 = 32'h0000_5020;
    localparam logic [5:0]  OPS [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                                         6'h03, 6'h0F, 6'h08, 6'h28, 6'h29, 6'h20};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] id_ins;
    logic [4:0]  id_rd;
    logic        id_rw;
    logic        id_mr;
    logic        br;

    logic [31:0] ex_ins_w [3];
    logic [31:0] ex_rd_w  [3];
    logic        ex_rw_w  [3];
    logic        ex_mr_w  [3];
    logic        pcw_w    [3];
    logic        ifw_w    [3];
    logic        fl_w     [3];
    logic [15:0] cnt_w    [3];

    int checks = 0;
    int errors = 0;

    id_ex_hazard_stage #(.LOAD_STALL_CYCLES(1)) dut1 (
        .Clk(clk), .Reset(rst_n), .ID_Instruction(id_ins), .ID_RegisterDestination(id_rd),
        .ID_RegisterWrite(id_rw), .ID_MemRead(id_mr), .BranchTaken(br),
        .EX_Instruction(ex_ins_w[0]), .EX_RegisterDestination(ex_rd_w[0]),
        .EX_RegisterWrite(ex_rw_w[0]), .EX_MemRead(ex_mr_w[0]), .PCWrite(pcw_w[0]),
        .IFIDWrite(ifw_w[0]), .IFIDFlush(fl_w[0]), .StallCount(cnt_w[0]));

    id_ex_hazard_stage #(.LOAD_STALL_CYCLES(3)) dut3 (
        .Clk(clk), .Reset(rst_n), .ID_Instruction(id_ins), .ID_RegisterDestination(id_rd),
        .ID_RegisterWrite(id_rw), .ID_MemRead(id_mr), .BranchTaken(br),
        .EX_Instruction(ex_ins_w[1]), .EX_RegisterDestination(ex_rd_w[1]),
        .EX_RegisterWrite(ex_rw_w[1]), .EX_MemRead(ex_mr_w[1]), .PCWrite(pcw_w[1]),
        .IFIDWrite(ifw_w[1]), .IFIDFlush(fl_w[1]), .StallCount(cnt_w[1]));

    id_ex_hazard_stage #(.LOAD_STALL_CYCLES(7)) dut7 (
        .Clk(clk), .Reset(rst_n), .ID_Instruction(id_ins), .ID_RegisterDestination(id_rd),
        .ID_RegisterWrite(id_rw), .ID_MemRead(id_mr), .BranchTaken(br),
        .EX_Instruction(ex_ins_w[2]), .EX_RegisterDestination(ex_rd_w[2]),
        .EX_RegisterWrite(ex_rw_w[2]), .EX_MemRead(ex_mr_w[2]), .PCWrite(pcw_w[2]),
        .IFIDWrite(ifw_w[2]), .IFIDFlush(fl_w[2]), .StallCount(cnt_w[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic [31:0] ins,
                         input logic [4:0] rd, input logic rw, input logic mr);
        rst_n  = r;
        br     = b;
        id_ins = ins;
        id_rd  = rd;
        id_rw  = rw;
        id_mr  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ins  [3];
    logic [4:0]  m_rd   [3];
    logic        m_rw   [3];
    logic        m_mr   [3];
    int          m_pend [3];
    int          m_cnt  [3];

    function automatic int bubbles_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 7);
    endfunction

    function automatic bit rs_read(input logic [31:0] ins);
        return !(ins[31:26] == 6'd2 || ins[31:26] == 6'd3 || ins[31:26] == 6'd15);
    endfunction

    function automatic bit rt_read(input logic [31:0] ins);
        return ins[31:26] == 6'd0 || ins[31:26] == 6'd4 || ins[31:26] == 6'd5 ||
               ins[31:26] == 6'd43 || ins[31:26] == 6'd40 || ins[31:26] == 6'd41;
    endfunction

    function automatic bit model_hazard(input int k);
        if (!(m_mr[k] && m_rw[k] && m_rd[k] != 5'd0)) return 1'b0;
        return (rs_read(id_ins) && id_ins[25:21] == m_rd[k]) ||
               (rt_read(id_ins) && id_ins[20:16] == m_rd[k]);
    endfunction

    task automatic model_bubble(input int k);
        m_ins[k] = 32'd0;
        m_rd[k]  = 5'd0;
        m_rw[k]  = 1'b0;
        m_mr[k]  = 1'b0;
    endtask

    task automatic model_cycle(input bit do_check);
        logic [2:0] exp_ctl;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n)                               exp_ctl = 3'b000;
            else if (br)                              exp_ctl = 3'b111;
            else if (m_pend[k] > 0 || model_hazard(k)) exp_ctl = 3'b000;
            else                                      exp_ctl = 3'b110;
            if (do_check)
                check($sformatf("ctl_dut%0d", k), {61'd0, pcw_w[k], ifw_w[k], fl_w[k]}, {61'd0, exp_ctl});
            if (!rst_n) begin
                model_bubble(k);
                m_pend[k] = 0;
                m_cnt[k]  = 0;
            end else if (br) begin
                model_bubble(k);
                m_pend[k] = 0;
            end else if (m_pend[k] > 0 || model_hazard(k)) begin
                m_pend[k] = (m_pend[k] > 0) ? m_pend[k] - 1 : bubbles_of(k) - 1;
                model_bubble(k);
                if (m_cnt[k] < 65535) m_cnt[k]++;
            end else begin
                m_ins[k] = id_ins;
                m_rd[k]  = id_rd;
                m_rw[k]  = id_rw;
                m_mr[k]  = id_mr;
            end
        end
        tick();
        if (do_check) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("ex_ins_dut%0d", k), {32'd0, ex_ins_w[k]}, {32'd0, m_ins[k]});
                check($sformatf("ex_rd_dut%0d", k), {32'd0, ex_rd_w[k]}, {59'd0, m_rd[k]});
                check($sformatf("ex_ctl_dut%0d", k), {62'd0, ex_rw_w[k], ex_mr_w[k]}, {62'd0, m_rw[k], m_mr[k]});
                check($sformatf("cnt_dut%0d", k), {48'd0, cnt_w[k]}, 64'(m_cnt[k]));
            end
        end
    endtask

    // ---------------- directed vectors (1-bubble instance) ----------------
    typedef struct {
        logic        rst;
        logic        brt;
        logic [31:0] ins;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [2:0]  exp_ctl;
        logic [31:0] exp_ins;
        logic [4:0]  exp_rd;
        logic        exp_rw;
        logic        exp_mr;
        logic [15:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic b, input logic [31:0] ins,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic [2:0] ctl, input logic [31:0] eins,
                                input logic [4:0] erd, input logic erw, input logic emr,
                                input logic [15:0] ecnt);
        vec_t v;
        v.rst = r; v.brt = b; v.ins = ins; v.rd = rd; v.rw = rw; v.mr = mr;
        v.exp_ctl = ctl; v.exp_ins = eins; v.exp_rd = erd; v.exp_rw = erw;
        v.exp_mr = emr; v.exp_cnt = ecnt;
        return v;
    endfunction

    vec_t vt [14];

    task automatic random_inputs();
        logic [31:0] ins;
        ins = {OPS[$urandom_range(0, 11)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               16'($urandom)};
        drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0), ins,
              5'($urandom_range(0, 3)), 1'($urandom),
              (ins[31:26] == 6'h23 || ins[31:26] == 6'h20) ? ($urandom_range(0, 3) != 0)
                                                           : ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

        vt[0]  = mk(0, 0, LW8,  5'd8,  1, 1, 3'b000, 32'd0, 5'd0,  0, 0, 16'd0);
        vt[1]  = mk(1, 0, LW8,  5'd8,  1, 1, 3'b110, LW8,   5'd8,  1, 1, 16'd0);
        vt[2]  = mk(1, 0, ADD,  5'd9,  1, 0, 3'b000, 32'd0, 5'd0,  0, 0, 16'd1);
        vt[3]  = mk(1, 0, ADD,  5'd9,  1, 0, 3'b110, ADD,   5'd9,  1, 0, 16'd1);
        vt[4]  = mk(1, 0, LW8,  5'd8,  1, 1, 3'b110, LW8,   5'd8,  1, 1, 16'd1);
        vt[5]  = mk(1, 0, SW,   5'd0,  0, 0, 3'b000, 32'd0, 5'd0,  0, 0, 16'd2);
        vt[6]  = mk(1, 0, SW,   5'd0,  0, 0, 3'b110, SW,    5'd0,  0, 0, 16'd2);
        vt[7]  = mk(1, 0, LW8,  5'd8,  1, 1, 3'b110, LW8,   5'd8,  1, 1, 16'd2);
        vt[8]  = mk(1, 0, JMP,  5'd0,  0, 0, 3'b110, JMP,   5'd0,  0, 0, 16'd2);
        vt[9]  = mk(1, 0, LW0,  5'd0,  1, 1, 3'b110, LW0,   5'd0,  1, 1, 16'd2);
        vt[10] = mk(1, 0, ADD0, 5'd10, 1, 0, 3'b110, ADD0,  5'd10, 1, 0, 16'd2);
        vt[11] = mk(1, 0, LW8,  5'd8,  1, 1, 3'b110, LW8,   5'd8,  1, 1, 16'd2);
        vt[12] = mk(1, 1, ADD,  5'd9,  1, 0, 3'b111, 32'd0, 5'd0,  0, 0, 16'd2);
        vt[13] = mk(0, 0, LW8,  5'd8,  1, 1, 3'b000, 32'd0, 5'd0,  0, 0, 16'd0);

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rst, vt[i].brt, vt[i].ins, vt[i].rd, vt[i].rw, vt[i].mr);
            check($sformatf("vec%0d_ctl", i), {61'd0, pcw_w[0], ifw_w[0], fl_w[0]}, {61'd0, vt[i].exp_ctl});
            tick();
            check($sformatf("vec%0d_ex_ins", i), {32'd0, ex_ins_w[0]}, {32'd0, vt[i].exp_ins});
            check($sformatf("vec%0d_ex_rd", i), {32'd0, ex_rd_w[0]}, {59'd0, vt[i].exp_rd});
            check($sformatf("vec%0d_ex_rwmr", i), {62'd0, ex_rw_w[0], ex_mr_w[0]},
                  {62'd0, vt[i].exp_rw, vt[i].exp_mr});
            check($sformatf("vec%0d_cnt", i), {48'd0, cnt_w[0]}, {48'd0, vt[i].exp_cnt});
        end

        // Three-bubble stall on the 3-cycle instance.
        drive(1, 0, LW8, 5'd8, 1, 1); tick();
        drive(1, 0, ADD, 5'd9, 1, 0);
        for (int b = 1; b <= 3; b++) begin
            check($sformatf("mc_pc_%0d", b), {63'd0, pcw_w[1]}, 64'd0);
            tick();
            check($sformatf("mc_bubble_%0d", b), {32'd0, ex_ins_w[1]}, 64'd0);
            check($sformatf("mc_cnt_%0d", b), {48'd0, cnt_w[1]}, 64'(b));
        end
        check("mc_release_pc", {63'd0, pcw_w[1]}, 64'd1);
        tick();
        check("mc_dep_ins", {32'd0, ex_ins_w[1]}, {32'd0, ADD});
        check("mc_dep_rd", {32'd0, ex_rd_w[1]}, 64'd9);

        // Branch taken on the second STALL cycle.
        drive(0, 0, LW8, 5'd8, 1, 1); tick();
        drive(1, 0, LW8, 5'd8, 1, 1); tick();
        drive(1, 0, ADD, 5'd9, 1, 0); tick(); tick();
        drive(1, 1, ADD, 5'd9, 1, 0);
        check("br_flush", {62'd0, fl_w[1], pcw_w[1]}, 64'd3);
        tick();
        check("br_cnt", {48'd0, cnt_w[1]}, 64'd2);
        check("br_bubble", {32'd0, ex_ins_w[1]}, 64'd0);
        drive(1, 0, ADD, 5'd9, 1, 0);
        check("br_run_pc", {63'd0, pcw_w[1]}, 64'd1);

        // Reset during STALL.
        drive(0, 0, LW8, 5'd8, 1, 1); tick();
        drive(1, 0, LW8, 5'd8, 1, 1); tick();
        drive(1, 0, ADD, 5'd9, 1, 0); tick();
        drive(0, 0, ADD, 5'd9, 1, 0);
        check("rst_ctl", {61'd0, pcw_w[1], ifw_w[1], fl_w[1]}, 64'd0);
        tick();
        check("rst_ex", {ex_ins_w[1], ex_rd_w[1]}, 64'd0);
        check("rst_rwmr_cnt", {46'd0, ex_rw_w[1], ex_mr_w[1], cnt_w[1]}, 64'd0);
        drive(1, 0, ADD, 5'd9, 1, 0);
        check("rst_run", {62'd0, pcw_w[1], ifw_w[1]}, 64'd3);

        // Random stimulus against the model.
        drive(0, 0, 32'd0, 5'd0, 0, 0);
        model_cycle(1'b1);
        for (int n = 0; n < 3000; n++) begin
            random_inputs();
            model_cycle(1'b1);
        end

        // Saturation: a self-dependent load keeps the stall engine busy.
        drive(0, 0, LW88, 5'd8, 1, 1);
        model_cycle(1'b1);
        drive(1, 0, LW88, 5'd8, 1, 1);
        for (int n = 0; n < 75000; n++) model_cycle(1'b0);
        check("sat_dut7", {48'd0, cnt_w[2]}, 64'hFFFF);
        for (int k = 0; k < 3; k++)
            check($sformatf("sat_model_dut%0d", k), {48'd0, cnt_w[k]}, 64'(m_cnt[k]));
        model_cycle(1'b1);
        check("sat_hold_dut7", {48'd0, cnt_w[2]}, 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

Pipeline register between decode and execute, with load-use hazard detection and branch-flush control. It latches the decoded instruction, destination register and write/read controls into the EX stage, where they drive the EX-stage forwarding logic. It inserts bubbles and freezes PC and IF/ID when an ID-stage instruction needs a value still being loaded. It also squashes the ID-stage instruction when a branch resolves taken in EX.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (legal range 1–7).

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- ID_Instruction  in  32  instruction currently in ID.
- ID_RegisterDestination  in  5  destination register selected in ID (rd/rt/31).
- ID_RegisterWrite  in  1  ID instruction writes the register file.
- ID_MemRead  in  1  ID instruction is a load.
- BranchTaken  in  1  branch/jump resolved taken in EX this cycle.
- EX_Instruction  out  32  registered instruction for EX.
- EX_RegisterDestination  out  32  registered destination, zero-extended from 5 bits.
- EX_RegisterWrite  out  1  registered write enable.
- EX_MemRead  out  1  registered load flag.
- PCWrite  out  1  PC update enable (combinational).
- IFIDWrite  out  1  IF/ID register enable (combinational).
- IFIDFlush  out  1  IF/ID clear (combinational).
- StallCount  out  16  saturating count of load-use bubbles inserted.

## Operation
- **Bubble:** EX_Instruction=0, EX_RegisterDestination=0, EX_RegisterWrite=0, EX_MemRead=0.
- **Source use.**
  - rs = ID_Instruction[25:21]. It is used unless the opcode is 000010 (j), 000011 (jal) or 001111 (lui).
  - rt = ID_Instruction[20:16]. It is used only for opcodes 000000, 000100, 000101, 101011, 101000 and 101001.
- **Hazard.** The hazard condition holds when all of the following are true:
  - EX_MemRead=1, EX_RegisterWrite=1 and EX_RegisterDestination≠0;
  - a used source equals EX_RegisterDestination[4:0].
- **States:** RUN and STALL, plus a 3-bit stall counter.
- **RUN, no hazard, BranchTaken=0:**
  - PCWrite=1, IFIDWrite=1, IFIDFlush=0.
  - EX registers load the ID inputs at the edge.
- **RUN, hazard, BranchTaken=0:**
  - PCWrite=0, IFIDWrite=0.
  - EX loads a bubble; StallCount increments.
  - If LOAD_STALL_CYCLES>1: cnt←LOAD_STALL_CYCLES-1 and state←STALL. Otherwise stay in RUN.
- **STALL:**
  - PCWrite=0, IFIDWrite=0.
  - EX loads a bubble; StallCount increments; cnt←cnt-1.
  - When cnt==1, state←RUN.
  - The hazard is not re-evaluated during STALL.
- **BranchTaken=1 (any state, highest priority):**
  - PCWrite=1, IFIDWrite=1, IFIDFlush=1.
  - EX loads a bubble; state←RUN; cnt←0.
  - StallCount does not increment.
- **StallCount:** saturates at 0xFFFF and never wraps.

## Timing
- **Reset:** while Reset=0, at the edge all EX outputs, StallCount, cnt and state return to bubble/0/0/RUN. In the same cycle the combinational outputs are forced to PCWrite=0, IFIDWrite=0, IFIDFlush=0.
- **Latency:** ID inputs appear on the EX outputs one cycle after the edge.
- **Load-use penalty:** exactly LOAD_STALL_CYCLES bubbles. The dependent instruction enters EX LOAD_STALL_CYCLES+1 cycles after the load entered EX.
- **Combinational outputs:**
  - PCWrite, IFIDWrite and IFIDFlush depend only on the current state, the EX registers, ID_Instruction and BranchTaken.
  - There is no combinational path from ID_MemRead or ID_RegisterWrite to any output.
- **Reset during STALL:** the stall is aborted and the next cycle is RUN with EX holding a bubble.

## Test plan
- **Load-use on rs:** EX holds lw, dest 8, MemRead=1, RegWrite=1; ID=0x010A4820 (add $9,$8,$10).
  - Same cycle: PCWrite=0, IFIDWrite=0.
  - Next cycle: EX shows a bubble and StallCount=1.
  - Following cycle: EX_Instruction=0x010A4820 and EX_RegisterDestination=9.
- **Load-use on rt via store:** EX lw dest 8; ID=0xAD280004 (sw $8,4($9)). Required response: one bubble, then EX_Instruction=0xAD280004.
- **No false stall:**
  - EX lw dest 8 with ID=0x09000000 (j, bits 25:21=8): no stall.
  - EX lw dest 0 with ID using rs=0: no stall.
  - StallCount stays 0 in both cases.
- **Multi-cycle stall:** LOAD_STALL_CYCLES=3 with the rs hazard above. Required response: exactly 3 consecutive bubble cycles with PCWrite=0, StallCount=3, then the dependent instruction enters EX.
- **Branch during stall:** LOAD_STALL_CYCLES=3; assert BranchTaken on the second STALL cycle.
  - Same cycle: IFIDFlush=1, PCWrite=1.
  - Next cycle: RUN; StallCount=2.
- **Reset mid-stall and saturation:**
  - Reset low during STALL: next cycle all EX outputs 0, StallCount=0, RUN.
  - Hold hazards for 65540 bubble cycles: StallCount=0xFFFF.
